multdiv_issue_ctrl: RTL and testbench

Processor-side controller for the iterative multiplier/divider. It sits in the execute stage. When a `mul` or `div` arrives, it latches the operands and destination register and issues a one-cycle start pulse to the multdiv unit. It then stalls the pipeline until the unit's cycle counter raises ready (or a watchdog expires), and emits one register-file writeback, redirected to `$rstatus` ($30) on exception.

---
 rtl/multdiv_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - execute-stage issue/stall/writeback controller for the iterative multdiv unit
module multdiv_issue_ctrl #(
    parameter int          TIMEOUT = 40,
    parameter logic [31:0] EXC_MUL = 32'd4,
    parameter logic [31:0] EXC_DIV = 32'd5
) (
    input  logic        clock,
    input  logic        clr,
    input  logic        op_mult,
    input  logic        op_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;

    localparam logic [5:0] LAST   = 6'(TIMEOUT - 1);
    localparam logic [4:0] RSTATUS = 5'd30;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_div_q, is_div_d;
    logic        ctrl_mult_d, ctrl_div_d, wb_valid_d;
    logic [31:0] md_a_d, md_b_d, wb_data_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] exc_code;

    assign exc_code = is_div_q ? EXC_DIV : EXC_MUL;

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            is_div_q  <= 1'b0;
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            md_a      <= '0;
            md_b      <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            is_div_q  <= is_div_d;
            ctrl_mult <= ctrl_mult_d;
            ctrl_div  <= ctrl_div_d;
            md_a      <= md_a_d;
            md_b      <= md_b_d;
            wb_valid  <= wb_valid_d;
            wb_rd     <= wb_rd_d;
            wb_data   <= wb_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        is_div_d    = is_div_q;
        md_a_d      = md_a;
        md_b_d      = md_b;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd;
        wb_data_d   = wb_data;
        stall       = 1'b0;

        case (state_q)
            IDLE: begin
                stall = op_mult | op_div;
                if (op_mult | op_div) begin
                    md_a_d      = operand_a;
                    md_b_d      = operand_b;
                    rd_d        = rd;
                    // mult has priority when both decode bits are set
                    is_div_d    = ~op_mult;
                    ctrl_mult_d = op_mult;
                    ctrl_div_d  = ~op_mult;
                    state_d     = START;
                end
            end
            START: begin
                stall   = 1'b1;
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 6'd1;
                if (md_ready) begin
                    wb_valid_d = md_exception | (rd_q != 5'd0);
                    wb_rd_d    = md_exception ? RSTATUS : rd_q;
                    wb_data_d  = md_exception ? exc_code : md_result;
                    state_d    = WB;
                end else if (cnt_q == LAST) begin
                    // watchdog: the unit never answered, report it as an exception
                    wb_valid_d = 1'b1;
                    wb_rd_d    = RSTATUS;
                    wb_data_d  = exc_code;
                    state_d    = WB;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - self-checking bench for multdiv_issue_ctrl
module tb_multdiv_issue_ctrl;

    localparam int TO = 40;

    logic        clock = 1'b0;
    logic        clr;
    logic        op_mult, op_div;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd;
    logic [31:0] md_result;
    logic        md_exception, md_ready;
    logic        ctrl_mult, ctrl_div;
    logic [31:0] md_a, md_b;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    multdiv_issue_ctrl #(.TIMEOUT(TO), .EXC_MUL(32'd4), .EXC_DIV(32'd5)) dut (
        .clock(clock), .clr(clr), .op_mult(op_mult), .op_div(op_div),
        .operand_a(operand_a), .operand_b(operand_b), .rd(rd),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_a(md_a), .md_b(md_b),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          k;
        logic [31:0] res;
        logic        exc;
        logic        exp_valid;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_cm;
        logic        exp_cd;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wb_t;

    vec_t vecs[12];
    wb_t  sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_cm = 0;
    int   n_cd = 0;
    int   last_wb_cyc = -1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: every writeback strobe must match the oldest expected entry
    always @(negedge clock) begin
        wb_t e;
        if (ctrl_mult) n_cm++;
        if (ctrl_div)  n_cd++;
        if (wb_valid) begin
            last_wb_cyc = cyc;
            if (sb.size() == 0) begin
                check("wb_unexpected", 1'b0, {59'b0, wb_rd}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("wb_rd",    wb_rd == e.rd,     {59'b0, wb_rd},   {59'b0, e.rd});
                check("wb_data",  wb_data == e.data, {32'b0, wb_data}, {32'b0, e.data});
                check("wb_cycle", cyc == e.cyc,      64'(cyc),         64'(e.cyc));
            end
        end
    end

    task automatic run_op(input vec_t v);
        int  t0, last, bad, cm0, cd0;
        wb_t e;
        op_mult = v.m; op_div = v.d; operand_a = v.a; operand_b = v.b; rd = v.rd;
        md_result = v.res; md_exception = v.exc; md_ready = 1'b0;
        t0   = cyc;
        last = (v.k < 0) ? 2 + TO : 3 + v.k;
        if (v.exp_valid) begin
            e.rd = v.exp_rd; e.data = v.exp_data; e.cyc = t0 + last;
            sb.push_back(e);
        end
        cm0 = n_cm; cd0 = n_cd; bad = 0;
        for (int c = 0; c <= last; c++) begin
            md_ready = (v.k >= 0) && (c == 2 + v.k);
            @(negedge clock);
            if (stall != (c < last)) bad++;
            if (c == 1) begin
                check("ctrl_pulse", {ctrl_mult, ctrl_div} == {v.exp_cm, v.exp_cd},
                      {62'b0, ctrl_mult, ctrl_div}, {62'b0, v.exp_cm, v.exp_cd});
                check("md_ab", {md_a, md_b} == {v.a, v.b}, {md_a, md_b}, {v.a, v.b});
            end
            @(posedge clock); #1;
        end
        md_ready = 1'b0; op_mult = 1'b0; op_div = 1'b0;
        check("stall_window", bad == 0, 64'(bad), 64'd0);
        check("pulse_count", (n_cm - cm0 == int'(v.exp_cm)) && (n_cd - cd0 == int'(v.exp_cd)),
              64'((n_cm - cm0) * 16 + (n_cd - cd0)), 64'(int'(v.exp_cm) * 16 + int'(v.exp_cd)));
    endtask

    task automatic check_all_zero(input string name);
        check(name, {ctrl_mult, ctrl_div, md_a, md_b, stall, wb_valid, wb_rd, wb_data} == '0,
              {ctrl_mult, ctrl_div, stall, wb_valid, wb_rd, md_a[31:16], wb_data[31:0]}, 64'd0);
    endtask

    initial begin
        int t0, w0, w1, bad;
        //          m     d     a               b               rd     k   res             exc   valid rd     data            cm    cd
        vecs[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFFFFFD,   5'd5,  32, 32'hFFFFFFEB,   1'b0, 1'b1, 5'd5,  32'hFFFFFFEB,   1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'd10,         32'd0,          5'd8,  0,  32'hDEADBEEF,   1'b1, 1'b1, 5'd30, 32'd5,          1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'd3,          32'd4,          5'd12, -1, 32'h0,          1'b0, 1'b1, 5'd30, 32'd4,          1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'd9,          32'd9,          5'd0,  2,  32'h1234,       1'b0, 1'b0, 5'd0,  32'h0,          1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'd100,        32'd7,          5'd17, 8,  32'd14,         1'b0, 1'b1, 5'd17, 32'd14,         1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h7FFFFFFF,   32'd2,          5'd31, 1,  32'hFFFFFFFE,   1'b1, 1'b1, 5'd30, 32'd4,          1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'd6,          32'd2,          5'd2,  -1, 32'h0,          1'b0, 1'b1, 5'd30, 32'd5,          1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'd5,          32'd5,          5'd6,  TO - 1, 32'hABCD,   1'b0, 1'b1, 5'd6,  32'hABCD,       1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'd1,          32'd0,          5'd0,  3,  32'h0,          1'b1, 1'b1, 5'd30, 32'd5,          1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'd50,         32'd5,          5'd20, 4,  32'd10,         1'b0, 1'b1, 5'd20, 32'd10,         1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h100,        32'd2,          5'd3,  5,  32'h200,        1'b0, 1'b1, 5'd3,  32'h200,        1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h200,        32'd3,          5'd4,  5,  32'h600,        1'b0, 1'b1, 5'd4,  32'h600,        1'b1, 1'b0};

        clr = 1'b1; op_mult = 1'b0; op_div = 1'b0; operand_a = '0; operand_b = '0; rd = '0;
        md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset_state");
        clr = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i <= 8; i++) run_op(vecs[i]);

        // abort an operation in flight, then show the unit's late answer is ignored
        op_mult = 1'b1; operand_a = 32'h11; operand_b = 32'h22; rd = 5'd9;
        t0 = cyc;
        repeat (12) begin
            @(posedge clock); #1;
        end
        check("busy_before_clr", stall == 1'b1 && md_a == 32'h11, {31'b0, stall, md_a}, {31'b0, 1'b1, 32'h11});
        clr = 1'b1; op_mult = 1'b0;
        #1;
        check_all_zero("clr_mid_busy");
        @(posedge clock); #1;
        clr = 1'b0;
        md_ready = 1'b1; md_result = 32'h55; md_exception = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (wb_valid || stall || ctrl_mult || ctrl_div) bad++;
            @(posedge clock); #1;
        end
        md_ready = 1'b0; md_exception = 1'b0;
        check("no_wb_after_clr", bad == 0, 64'(bad), 64'd0);
        check("clr_cycles", cyc - t0 == 16, 64'(cyc - t0), 64'd16);

        run_op(vecs[9]);

        run_op(vecs[10]);
        w0 = last_wb_cyc;
        run_op(vecs[11]);
        w1 = last_wb_cyc;
        check("b2b_gap", w1 - w0 == 4 + vecs[10].k, 64'(w1 - w0), 64'(4 + vecs[10].k));

        repeat (2) @(posedge clock);
        check("sb_drained", sb.size() == 0, 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
